spi_regfile: RTL and testbench
==============================

# spi_regfile

Parametrised successor to the team's write-only SPI control-register peripheral. It decodes SPI mode-0 frames from an external controller into a bank of `NUM_REGS` registers of `DATA_W` bits and supports both writes and reads-back on `cipo`. It flags malformed frames and runs entirely in the `clk` domain, with all SPI pins synchronised. It sits between the chip-level SPI pins and the output-enable, PWM-enable and duty-cycle consumers, which tap the flattened register bus.

## Interface
- `ADDR_W`, 7: address field width in bits.
- `DATA_W`, 8: data field width and register width.
- `NUM_REGS`, 5: number of implemented registers, at addresses `0..NUM_REGS-1`. Requires NUM_REGS ≤ 2^ADDR_W.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `copi`  in  1  SPI controller-out data, asynchronous to `clk`.
- `ncs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `cipo`  out  1  SPI peripheral-out data.
- `cipo_oe`  out  1  output enable for the `cipo` pad.
- `regs_out`  out  NUM_REGS*DATA_W  flattened register bank; register k occupies bits `[k*DATA_W +: DATA_W]`.
- `wr_strobe`  out  1  one-cycle pulse on every committed write.
- `wr_addr`  out  ADDR_W  address of the last committed write.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- **Synchronisers.** `sclk`, `copi` and `ncs` each pass through a 2-flop synchroniser.
- **Edge detection.** A third flop on synced `sclk` and synced `ncs` provides edge detection. All SPI behaviour is driven by these detected edges.
- **Frame format.** FRAME = 1+ADDR_W+DATA_W bits, MSB first:
  - bit 0 is R/W (1 = write, 0 = read),
  - then ADDR_W address bits,
  - then DATA_W data bits.
- **SPI mode.** Mode 0: `copi` is sampled on the sclk rising edge, and `cipo` is updated on the sclk falling edge.
- **Bit counter.** Width is clog2(FRAME+2) bits. It counts sampled bits and saturates at FRAME+1, which marks the frame as overlong.
- **FSM states:**
  - IDLE: `cipo_oe`=0, bit counter held at 0. On ncs falling edge → SHIFT.
  - SHIFT: each sclk rise shifts synced `copi` into the shift register and increments the counter.
    - When the counter reaches 1+ADDR_W with R/W=0, the read buffer loads the addressed register, or 0 if the address ≥ NUM_REGS.
    - On the following sclk falls, `cipo` presents the read buffer MSB-first, shifting one bit per fall.
    - On ncs rising edge → COMMIT.
  - COMMIT (1 cycle):
    - If count == FRAME, R/W=1 and addr < NUM_REGS: write the register, assert `wr_strobe`, update `wr_addr`.
    - If count ≠ FRAME (short or overlong frame): assert `frame_err`, no write.
    - A read frame of correct length, or a write to address ≥ NUM_REGS: no write, no error.
    - Then → IDLE.
- **`cipo` during SHIFT.** Drives 0 during the command/address phase and during any write frame. `cipo_oe` = 1 throughout SHIFT.
- **Reset values.**
  - All `regs_out` = 0, `cipo` = 0, `cipo_oe` = 0, `wr_strobe` = 0, `wr_addr` = 0, `frame_err` = 0.
  - FSM = IDLE.
  - Synchroniser flops reset to the idle pin levels: ncs = 1, sclk = 0.
- **Reset mid-frame.** The FSM returns to IDLE. Because synced `ncs` is reset high, an `ncs` that is already low is seen as a fresh falling edge. The remaining partial frame is then too short and is discarded with `frame_err`; no register is modified.
- **Simultaneous events.** An sclk edge detected in the same cycle as the ncs rising edge is ignored. An ncs falling edge in IDLE while `rst`=1 is ignored; reset wins.

## Timing
- **Pin-to-detect latency.** 3 `clk` cycles from pin transition to edge detection.
- **Clock ratio.** `clk` ≥ 8× `sclk`. Each sclk high and low phase must be ≥ 4 `clk` cycles.
- **Chip-select setup.** `ncs` low must precede the first sclk rise by ≥ 4 `clk` cycles.
- **Write latency.** `regs_out` and `wr_addr` update in the cycle after the ncs-rise detection, i.e. 4 `clk` after the pin rises. `wr_strobe` is high in that same cycle.
- **Read data.** The read buffer loads in the cycle after the last address bit is sampled. The first data bit appears on `cipo` within 1 `clk` of the next sclk-fall detection and is held until the following fall.
- **Back-to-back frames.** Minimum ncs-high time between frames is 2 `clk` cycles post-synchronisation.

## Test plan
- **Write.** Default params; frame 1_0000000_10100101 → `regs_out[7:0]`=0xA5, single `wr_strobe`, `wr_addr`=0, other registers stay 0.
- **Read-back.** Write 0x3C to address 4, then send read frame 0_0000100_xxxxxxxx → `cipo` shifts out 0,0,1,1,1,1,0,0; `regs_out` unchanged; no `wr_strobe`.
- **Short frame.** Write frame cut after 15 bits → no register change, one `frame_err` pulse, no `wr_strobe`.
- **Overlong frame.** 17-bit write frame → one `frame_err` pulse, no write.
- **Out-of-range address.** Write 0xFF to address 5 → no change, no `wr_strobe`, no `frame_err`. Read of address 9 → `cipo` all zeros.
- **Reset mid-frame.** Assert `rst` for 2 cycles after 6 bits of a write to address 1, then complete the frame → register 1 stays 0 and `frame_err` pulses once. The next full write frame to address 1 succeeds.

Source files
------------

// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral decoding R/W frames into a bank of registers with read-back on cipo
module spi_regfile #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CW    = $clog2(FRAME + 2);
    localparam logic [CW-1:0] FULL  = CW'(FRAME);
    localparam logic [CW-1:0] OVER  = CW'(FRAME + 1);
    localparam logic [CW-1:0] ALAST = CW'(ADDR_W);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              st_q;
    logic [2:0]          sclk_q, ncs_q;
    logic [1:0]          copi_q;
    logic [CW-1:0]       cnt_q;
    logic [FRAME-1:0]    sr_q;
    logic [DATA_W-1:0]   rbuf_q, rd_val;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                ld_q, rd_q, cipo_q, oe_q, wr_strobe_q, frame_err_q, c_hit;
    logic [ADDR_W-1:0]   wr_addr_q;

    wire sclk_rise = sclk_q[1] & ~sclk_q[2];
    wire sclk_fall = ~sclk_q[1] & sclk_q[2];
    wire ncs_fall  = ~ncs_q[1] & ncs_q[2];
    wire ncs_rise  = ncs_q[1] & ~ncs_q[2];
    wire [ADDR_W-1:0] c_addr = sr_q[DATA_W +: ADDR_W];
    wire              wr_ok  = (cnt_q == FULL) && sr_q[FRAME-1] && c_hit;

    // Two-flop synchronisers plus a third edge-detect flop, reset to idle pin levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            ncs_q  <= 3'b111;
            copi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ncs_q  <= {ncs_q[1:0], ncs};
            copi_q <= {copi_q[0], copi};
        end
    end

    // Address decode: read-back value for the early address and range hit for the commit address
    always_comb begin
        rd_val = '0;
        c_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sr_q[ADDR_W-1:0] == ADDR_W'(k)) rd_val = regs_q[k];
            if (c_addr == ADDR_W'(k)) c_hit = 1'b1;
        end
    end

    // Frame FSM: shift in bits, serve reads on falling edges, commit or flag on chip-select release
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            rbuf_q      <= '0;
            ld_q        <= 1'b0;
            rd_q        <= 1'b0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            ld_q        <= 1'b0;
            case (st_q)
                IDLE: begin
                    cnt_q  <= '0;
                    rd_q   <= 1'b0;
                    cipo_q <= 1'b0;
                    if (ncs_fall) begin
                        st_q <= SHIFT;
                        oe_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        st_q   <= COMMIT;
                        oe_q   <= 1'b0;
                        cipo_q <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            if (cnt_q != OVER) cnt_q <= cnt_q + 1'b1;
                            if (cnt_q < FULL) sr_q <= {sr_q[FRAME-2:0], copi_q[1]};
                            ld_q <= (cnt_q == ALAST);
                        end
                        if (ld_q) begin
                            rd_q   <= ~sr_q[ADDR_W];
                            rbuf_q <= rd_val;
                        end else if (sclk_fall) begin
                            cipo_q <= rd_q & rbuf_q[DATA_W-1];
                            rbuf_q <= rbuf_q << 1;
                        end
                    end
                end
                COMMIT: begin
                    st_q <= IDLE;
                    if (cnt_q != FULL) frame_err_q <= 1'b1;
                    else if (wr_ok) begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= c_addr;
                    end
                    for (int k = 0; k < NUM_REGS; k++)
                        if (wr_ok && c_addr == ADDR_W'(k)) regs_q[k] <= sr_q[DATA_W-1:0];
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_out[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed SPI frame tests for spi_regfile
module tb_spi_regfile;
    logic        clk = 1'b0;
    logic        rst, sclk, copi, ncs;
    logic        cipo, cipo_oe, wr_strobe, frame_err;
    logic [39:0] regs_out;
    logic [6:0]  wr_addr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rx;
    int          ns, ne;
    logic        oe_seen;

    spi_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends n bits MSB-first; optionally pulses rst after bit index rst_at (counting down)
    task automatic send(input logic [31:0] bits, input int n, input int rst_at);
        rx = '0;
        ns = 0;
        ne = 0;
        oe_seen = 1'b0;
        ncs = 1'b0;
        #60;
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            #60;
            rx = {rx[30:0], cipo};
            if (i == n - 1) oe_seen = cipo_oe;
            sclk = 1'b1;
            #60;
            sclk = 1'b0;
            if (i == rst_at) begin
                @(negedge clk) rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        #60;
        ncs = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wr_strobe) ns++;
            if (frame_err) ne++;
        end
        #40;
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_regs", regs_out, 40'h0);
        check("rst_cipo", cipo, 1'b0);
        check("rst_oe", cipo_oe, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_waddr", wr_addr, 7'd0);
        check("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send(32'h80A5, 16, -1);
        check("wr0_regs", regs_out, 40'h00_0000_00A5);
        check("wr0_strobe", ns, 1);
        check("wr0_err", ne, 0);
        check("wr0_waddr", wr_addr, 7'd0);
        check("wr0_oe", oe_seen, 1'b1);

        send(32'h843C, 16, -1);
        check("wr4_regs", regs_out, 40'h3C_0000_00A5);
        check("wr4_strobe", ns, 1);
        check("wr4_waddr", wr_addr, 7'd4);

        send(32'h0400, 16, -1);
        check("rd4_data", rx[7:0], 8'h3C);
        check("rd4_cmd_zero", rx[15:8], 8'h00);
        check("rd4_strobe", ns, 0);
        check("rd4_err", ne, 0);
        check("rd4_regs", regs_out, 40'h3C_0000_00A5);
        check("idle_oe", cipo_oe, 1'b0);

        send(32'h8177 >> 1, 15, -1);
        check("short_err", ne, 1);
        check("short_strobe", ns, 0);
        check("short_regs", regs_out, 40'h3C_0000_00A5);

        send({15'd0, 16'h8177, 1'b1}, 17, -1);
        check("long_err", ne, 1);
        check("long_strobe", ns, 0);
        check("long_regs", regs_out, 40'h3C_0000_00A5);

        send(32'h85FF, 16, -1);
        check("oor_regs", regs_out, 40'h3C_0000_00A5);
        check("oor_strobe", ns, 0);
        check("oor_err", ne, 0);
        check("oor_waddr", wr_addr, 7'd4);

        send(32'h0900, 16, -1);
        check("rd9_data", rx[15:0], 16'h0000);
        check("rd9_err", ne, 0);

        send(32'h8155, 16, 10);
        check("mid_err", ne, 1);
        check("mid_strobe", ns, 0);
        check("mid_regs", regs_out, 40'h0);

        send(32'h8155, 16, -1);
        check("wr1_regs", regs_out, 40'h00_0000_5500);
        check("wr1_strobe", ns, 1);
        check("wr1_waddr", wr_addr, 7'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
